protocol_job_arbiter: RTL and testbench
=======================================

Name: protocol_job_arbiter

Overview:
- Shares one protocol_controller engine among NUM_REQ requesters.
- Each requester posts a job: a 2-bit protocol code plus 8 bits of data.
- The arbiter grants jobs round-robin and sequences the engine's select/data pins through its IDLE→PROTOCOL→WAIT handshake. It then routes the 8-bit result back to the winning requester.
- It sits between the requester fabric and the engine; it is the only driver of the engine's protocol_select and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the requester index; must be at least clog2(NUM_REQ).
- TIMEOUT, 15, maximum WAIT cycles before a job is aborted (used only with JOB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- req  in  NUM_REQ  per-requester job request, level
- req_proto  in  2*NUM_REQ  protocol code; slice [2i+1:2i] belongs to requester i
- req_data  in  8*NUM_REQ  job data; slice [8i+7:8i] belongs to requester i
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when a job is accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse when the result is ready
- rsp_data  out  8  result, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- eng_sel  out  2  to engine protocol_select
- eng_data  out  8  to engine data_in
- eng_busy  in  1  from engine busy
- eng_done  in  1  from engine done
- eng_result  in  8  from engine data_out
- arb_state  out  3  current FSM state, debug
- cur_idx  out  IDX_W  index of the active requester, debug

Behaviour:
- Clocking and reset: the clock is clk; reset is reset, asynchronous, active-high.
- Reset values: all outputs 0; eng_sel=00; state IDLE; round-robin pointer 0.
- All outputs are registered. Reset mid-job drops eng_sel to 00 immediately, with no rsp_valid.

States (arb_state encoding):
- IDLE=0
  - Arbitrate only when eng_busy=0 and req is non-zero.
  - Winner = first set bit of req at or after the pointer, wrapping modulo NUM_REQ.
  - On the edge: latch winner index, proto and data; pointer := winner+1 (wraps).
  - If the latched proto ≠ 00, go ISSUE; if it is 00, go RESP with the error flag set.
  - While in IDLE, eng_sel=00.
- ISSUE=1
  - gnt[idx]=1 for this cycle only.
  - eng_sel=proto, eng_data=data; the engine samples the select in its IDLE.
  - Go HOLD.
- HOLD=2
  - eng_sel and eng_data are held unchanged; the engine latches them in its PROTOCOL_x state.
  - Go WAIT.
- WAIT=3
  - eng_sel=00 and eng_data=00 for the whole state, so the engine cannot relaunch after done.
  - On eng_done=1: capture eng_result and go RESP.
  - Completion is detected only through eng_done, never by cycle counting.
  - Nominal timing: eng_done appears in the 5th cycle after ISSUE (ISSUE=cycle 0).
- RESP=4
  - rsp_valid[idx]=1; rsp_data is the captured value, or 0 on error; rsp_err is the error flag.
  - Go IDLE, clearing the error flag.
- Any illegal state goes to IDLE.

Requester rules:
- req_proto and req_data are sampled only on the IDLE→ISSUE/RESP edge.
- The requester must drop req within 1 cycle of seeing gnt; if req is still high when the FSM returns to IDLE, it is treated as a new job.
- For a proto=00 job, gnt is pulsed in the RESP cycle together with rsp_valid.

Boundary conditions:
- Simultaneous requests: exactly one grant per job, and the pointer guarantees fairness.
- eng_done seen outside WAIT is ignored.
- A single requester with req held high is re-granted back-to-back, with one IDLE cycle between jobs.

Optional Feature:
- Macro: JOB_TIMEOUT_EN.
- Defined:
  - A 4-bit WAIT counter resets on entry to WAIT.
  - If TIMEOUT cycles elapse without eng_done, go RESP with rsp_err=1 and rsp_data=0.
  - A late eng_done is ignored.
- Undefined:
  - WAIT lasts until eng_done, with no limit.
  - TIMEOUT is unused and no counter logic is synthesized.

Test Plan:
- Single job: req[1], proto=01, data=0x41 → gnt[1] 1 cycle after req; rsp_valid[1] with rsp_data=0x42 and rsp_err=0, 6 cycles after gnt.
- Protocols B and C back-to-back from req[0]: (10,0x0F)→0xF0, then (11,0x55)→0xFF; eng_sel reads 00 throughout each WAIT.
- Round-robin: req=4'b0101 held high, pointer=0 → grant order 0,2,0,2. Then req=4'b1111 after a grant to 2 → next grants 3,0,1,2.
- Invalid job: req[3], proto=00 → gnt[3] and rsp_valid[3] in the same cycle, rsp_err=1, rsp_data=0x00; eng_sel never leaves 00.
- Reset asserted during WAIT → all outputs 0 in the same cycle, no rsp_valid. After release, a new request is granted starting from requester 0.
- JOB_TIMEOUT_EN with TIMEOUT=15 and eng_done tied low → rsp_err=1 and rsp_data=0 after 15 WAIT cycles; a late eng_done pulse causes no second rsp_valid.

Source files
------------

// File: rtl/protocol_job_arbiter.sv
// Round-robin arbiter sharing one protocol_controller engine among NUM_REQ requesters.
// Optional WAIT-state timeout: define JOB_TIMEOUT_EN (limit set by TIMEOUT).
module protocol_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_proto,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic [1:0]             eng_sel,
  output logic [7:0]             eng_data,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic [7:0]             eng_result,
  output logic [2:0]             arb_state,
  output logic [IDX_W-1:0]       cur_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Elaboration-time sanity check of the parameter set.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 15 ||
      (1 << IDX_W) < NUM_REQ) begin : g_param_check
    $error("protocol_job_arbiter: illegal parameter combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;

`ifdef JOB_TIMEOUT_EN
  logic [3:0]         wait_cnt;
`endif

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   ptr_next;
  logic [1:0]         win_proto;
  logic [7:0]         win_data;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] idx_onehot;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    win_proto  = req_proto[2*win_idx +: 2];
    win_data   = req_data[8*win_idx +: 8];
    win_onehot = NUM_REQ'(1) << win_idx;
    idx_onehot = NUM_REQ'(1) << idx;
  end

  assign arb_state = state;
  assign cur_idx   = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_sel   <= '0;
      eng_data  <= '0;
`ifdef JOB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          eng_sel  <= '0;
          eng_data <= '0;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
          if (!eng_busy && win_found) begin
            idx <= win_idx;
            ptr <= ptr_next;
            gnt <= win_onehot;
            if (win_proto != 2'b00) begin
              state    <= S_ISSUE;
              eng_sel  <= win_proto;
              eng_data <= win_data;
            end else begin
              // Invalid protocol: grant and reject in the same cycle, engine untouched.
              state     <= S_RESP;
              rsp_valid <= win_onehot;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Select is cleared for all of WAIT so the engine cannot relaunch after done.
          state    <= S_WAIT;
          eng_sel  <= '0;
          eng_data <= '0;
`ifdef JOB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (eng_done) begin
            state     <= S_RESP;
            rsp_valid <= idx_onehot;
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
          end
`ifdef JOB_TIMEOUT_EN
          else if (wait_cnt == 4'(TIMEOUT - 1)) begin
            state     <= S_RESP;
            rsp_valid <= idx_onehot;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        S_RESP: begin
          state    <= S_IDLE;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          eng_sel  <= '0;
          eng_data <= '0;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_protocol_job_arbiter.sv
// Directed self-checking bench for protocol_job_arbiter with a behavioural engine model.
module tb_protocol_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_proto;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_err;
  logic [1:0]           eng_sel;
  logic [7:0]           eng_data;
  logic                 eng_busy;
  logic                 eng_done;
  logic [7:0]           eng_result;
  logic [2:0]           arb_state;
  logic [IDX_W-1:0]     cur_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic       done_en;
  logic       done_force;
  logic [2:0] t;
  logic [1:0] m_sel;
  logic [7:0] m_res;

  always #5 clk = ~clk;

  protocol_job_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req(req), .req_proto(req_proto), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_sel(eng_sel), .eng_data(eng_data), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_result(eng_result), .arb_state(arb_state), .cur_idx(cur_idx)
  );

  // Engine model: A=data+1, B=~data, C=data^AA; done in the 5th cycle after launch.
  function automatic logic [7:0] eng_fn(input logic [1:0] s, input logic [7:0] d);
    case (s)
      2'b01:   return d + 8'd1;
      2'b10:   return ~d;
      default: return d ^ 8'hAA;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t     <= '0;
      m_sel <= '0;
      m_res <= '0;
    end else if (t == 3'd0) begin
      if (eng_sel != 2'b00) begin
        t     <= 3'd1;
        m_sel <= eng_sel;
      end
    end else if (t == 3'd1) begin
      m_res <= eng_fn(m_sel, eng_data);
      t     <= 3'd2;
    end else if (t == 3'd5) begin
      t <= 3'd0;
    end else begin
      t <= t + 3'd1;
    end
  end

  assign eng_busy   = (t != 3'd0);
  assign eng_done   = ((t == 3'd5) && done_en) || done_force;
  assign eng_result = m_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int i, input logic [1:0] p, input logic [7:0] d);
    req_proto[2*i +: 2] = p;
    req_data[8*i +: 8]  = d;
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp);
    int unsigned k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == '0 && k < 30);
    chk(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic wait_rsp(input string tag, input logic [3:0] exp, input logic [7:0] d);
    int unsigned k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rsp_valid == '0 && k < 30);
    chk({tag, "_v"}, 32'(rsp_valid), 32'(exp));
    chk({tag, "_d"}, 32'(rsp_data), 32'(d));
  endtask

  initial begin
    reset = 1'b1; req = '0; req_proto = '0; req_data = '0;
    done_en = 1'b1; done_force = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_sel", 32'(eng_sel), 0);
    chk("rst_idx", 32'(cur_idx), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single job, protocol A on requester 1
    set_job(1, 2'b01, 8'h41); req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_sel", 32'(eng_sel), 1);
    chk("t1_data", 32'(eng_data), 32'h41);
    chk("t1_idx", 32'(cur_idx), 1);
    chk("t1_issue", 32'(arb_state), 1);
    req = '0;
    @(negedge clk);
    chk("t1_hold", 32'(arb_state), 2);
    chk("t1_hold_sel", 32'(eng_sel), 1);
    chk("t1_gnt_pulse", 32'(gnt), 0);
    @(negedge clk);
    chk("t1_wait", 32'(arb_state), 3);
    chk("t1_wait_sel", 32'(eng_sel), 0);
    chk("t1_wait_data", 32'(eng_data), 0);
    repeat (3) @(negedge clk);
    chk("t1_no_early_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rspv", 32'(rsp_valid), 32'h2);
    chk("t1_rspd", 32'(rsp_data), 32'h42);
    chk("t1_rspe", 32'(rsp_err), 0);
    @(negedge clk);
    chk("t1_idle", 32'(arb_state), 0);
    chk("t1_rspv_pulse", 32'(rsp_valid), 0);

    // Protocols B then C back-to-back from requester 0, req held high
    set_job(0, 2'b10, 8'h0F); req = 4'b0001;
    @(negedge clk);
    chk("t2_gnt_b", 32'(gnt), 1);
    chk("t2_sel_b", 32'(eng_sel), 2);
    set_job(0, 2'b11, 8'h55);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_wait_sel_b", 32'(eng_sel), 0);
    end
    @(negedge clk);
    chk("t2_rspv_b", 32'(rsp_valid), 1);
    chk("t2_rspd_b", 32'(rsp_data), 32'hF0);
    @(negedge clk);
    chk("t2_gap_idle", 32'(arb_state), 0);
    chk("t2_gap_gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("t2_gnt_c", 32'(gnt), 1);
    chk("t2_sel_c", 32'(eng_sel), 3);
    chk("t2_data_c", 32'(eng_data), 32'h55);
    req = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_wait_sel_c", 32'(eng_sel), 0);
    end
    @(negedge clk);
    chk("t2_rspv_c", 32'(rsp_valid), 1);
    chk("t2_rspd_c", 32'(rsp_data), 32'hFF);
    chk("t2_rspe_c", 32'(rsp_err), 0);
    @(negedge clk);

    // Invalid protocol on requester 3
    set_job(3, 2'b00, 8'h77); req = 4'b1000;
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'h8);
    chk("t3_rspv", 32'(rsp_valid), 32'h8);
    chk("t3_rspe", 32'(rsp_err), 1);
    chk("t3_rspd", 32'(rsp_data), 0);
    chk("t3_sel", 32'(eng_sel), 0);
    chk("t3_state", 32'(arb_state), 4);
    req = '0;
    @(negedge clk);
    chk("t3_idle", 32'(arb_state), 0);
    chk("t3_rspv_pulse", 32'(rsp_valid), 0);
    chk("t3_rspe_clr", 32'(rsp_err), 0);
    chk("t3_sel_idle", 32'(eng_sel), 0);

    // Round-robin fairness
    set_job(0, 2'b01, 8'h10); set_job(1, 2'b01, 8'h30);
    set_job(2, 2'b01, 8'h20); set_job(3, 2'b01, 8'h40);
    req = 4'b0101;
    wait_gnt("rr_a0", 4'b0001);
    wait_gnt("rr_a2", 4'b0100);
    wait_gnt("rr_b0", 4'b0001);
    wait_gnt("rr_b2", 4'b0100);
    req = 4'b1111;
    wait_gnt("rr_c3", 4'b1000);
    wait_gnt("rr_c0", 4'b0001);
    wait_gnt("rr_c1", 4'b0010);
    wait_gnt("rr_c2", 4'b0100);
    req = '0;
    wait_rsp("rr_last", 4'b0100, 8'h21);
    @(negedge clk);

    // Reset during WAIT
    set_job(1, 2'b01, 8'h41); req = 4'b0010;
    wait_gnt("rst_pre_gnt", 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);
    chk("rst_pre_wait", 32'(arb_state), 3);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_state", 32'(arb_state), 0);
    chk("rst_mid_sel", 32'(eng_sel), 0);
    chk("rst_mid_data", 32'(eng_data), 0);
    chk("rst_mid_idx", 32'(cur_idx), 0);
    chk("rst_mid_gnt", 32'(gnt), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_rspv", 32'(rsp_valid), 0);
    end
    reset = 1'b0;
    req = 4'b1111;
    wait_gnt("rst_post_gnt", 4'b0001);
    req = '0;
    wait_rsp("rst_post", 4'b0001, 8'h11);
    @(negedge clk);

`ifdef JOB_TIMEOUT_EN
    done_en = 1'b0;
    set_job(2, 2'b01, 8'h99); req = 4'b0100;
    wait_gnt("to_gnt", 4'b0100);
    req = '0;
    repeat (16) @(negedge clk);
    chk("to_early", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("to_rspv", 32'(rsp_valid), 32'h4);
    chk("to_rspe", 32'(rsp_err), 1);
    chk("to_rspd", 32'(rsp_data), 0);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("to_late_done", 32'(rsp_valid), 0);
    end
    done_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
